// File: rtl/vospi_pkg.sv
// Shared types for the VoSPI packet parser: header constants, FSM states and
// the FIFO entry layout (fields sized for the widest supported configuration).
package vospi_pkg;

  localparam int unsigned header_bytes_c = 4;
  localparam logic [3:0]  discard_mask_c = 4'hF;

  typedef enum logic [2:0] {
    ID_HI,
    ID_LO,
    CRC_HI,
    CRC_LO,
    PAYLOAD
  } state_e;

  typedef struct packed {
    logic [23:0] pixel;
    logic [11:0] line;
    logic [11:0] col;
    logic        sof;
    logic        eol;
    logic        eof;
  } pixel_entry_t;

endpackage

// File: rtl/vospi_packet_parser_if.sv
// Valid/ready stream bundle carrying pixel entries out of the parser FIFO.
interface vospi_packet_parser_if
  import vospi_pkg::*;
#(
  parameter int unsigned width_p = $bits(pixel_entry_t)
);

  logic [width_p-1:0] data;
  logic               valid;
  logic               ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/vospi_out_fifo.sv
// First-word-fall-through FIFO; head reads as zero while empty.
module vospi_out_fifo #(
  parameter int unsigned width_p = 8,
  parameter int unsigned depth_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               wr_en_i,
  input  logic [width_p-1:0] wr_data_i,
  output logic               full_o,
  output logic               empty_o,
  vospi_packet_parser_if.master rd_if
);

  localparam int unsigned aw_c = (depth_p > 1) ? $clog2(depth_p) : 1;

  logic [width_p-1:0] mem_q [depth_p];
  logic [aw_c-1:0]    wr_ptr_q;
  logic [aw_c-1:0]    rd_ptr_q;
  logic [aw_c:0]      count_q;
  logic               rd_en;
  logic               wr_ok;

  assign full_o  = (count_q == (aw_c+1)'(depth_p));
  assign empty_o = (count_q == '0);
  assign rd_en   = rd_if.ready && !empty_o;
  // A read in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_ok   = wr_en_i && (!full_o || rd_en);

  assign rd_if.valid = !empty_o;
  assign rd_if.data  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({wr_ok, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vospi_packet_parser.sv
// VoSPI byte stream parser: header decode, discard/sequence filtering,
// big-endian pixel assembly and buffered valid/ready pixel output.
module vospi_packet_parser
  import vospi_pkg::*;
#(
  parameter int unsigned pixel_bytes_p = 2,
  parameter int unsigned line_pixels_p = 80,
  parameter int unsigned frame_lines_p = 60,
  parameter int unsigned fifo_depth_p  = 16
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [7:0]                       data_i,
  input  logic                             valid_i,
  output logic [8*pixel_bytes_p-1:0]       pixel_o,
  output logic [$clog2(frame_lines_p)-1:0] line_o,
  output logic [$clog2(line_pixels_p)-1:0] col_o,
  output logic                             sof_o,
  output logic                             eol_o,
  output logic                             eof_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic                             sync_err_o,
  output logic                             overflow_o
);

  localparam int unsigned pw_c  = 8 * pixel_bytes_p;
  localparam int unsigned lw_c  = $clog2(frame_lines_p);
  localparam int unsigned cw_c  = $clog2(line_pixels_p);
  localparam int unsigned pay_c = line_pixels_p * pixel_bytes_p;
  localparam int unsigned bw_c  = $clog2(pay_c);
  localparam int unsigned sw_c  = (pixel_bytes_p > 1) ? $clog2(pixel_bytes_p) : 1;
  localparam int unsigned shw_c = (pw_c > 8) ? pw_c - 8 : 1;
  localparam int unsigned ew_c  = $bits(pixel_entry_t);

  state_e           state_q;
  logic [3:0]       id_hi_q;
  logic             skip_q;
  logic             synced_q;
  logic             sync_err_q;
  logic             overflow_q;
  logic [lw_c-1:0]  expected_q;
  logic [lw_c-1:0]  line_q;
  logic [cw_c-1:0]  col_q;
  logic [bw_c-1:0]  byte_cnt_q;
  logic [sw_c-1:0]  sub_q;
  logic [shw_c-1:0] shift_q;

  logic [11:0]      num;
  logic             is_discard;
  logic             num_bad;
  logic             seq_bad;
  logic             last_byte;
  logic             last_sub;
  logic             pix_done;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_rd;
  logic [pw_c-1:0]  pixel_d;
  pixel_entry_t     wr_entry;
  pixel_entry_t     head;

  assign num        = {id_hi_q, data_i};
  assign is_discard = (id_hi_q == discard_mask_c);
  assign num_bad    = (32'(num) >= frame_lines_p);
  assign seq_bad    = (num != 12'(expected_q));
  assign last_byte  = (byte_cnt_q == bw_c'(pay_c - 1));
  assign last_sub   = (sub_q == sw_c'(pixel_bytes_p - 1));
  // Earlier bytes sit in the shift register; the current byte is the LSB.
  assign pixel_d    = pw_c'({shift_q, data_i});
  assign pix_done   = valid_i && (state_q == PAYLOAD) && !skip_q && last_sub;
  assign fifo_rd    = !fifo_empty && ready_i;
  assign drop       = pix_done && fifo_full && !fifo_rd;

  always_comb begin
    wr_entry       = '0;
    wr_entry.pixel = 24'(pixel_d);
    wr_entry.line  = 12'(line_q);
    wr_entry.col   = 12'(col_q);
    wr_entry.sof   = (line_q == '0) && (col_q == '0);
    wr_entry.eol   = (col_q == cw_c'(line_pixels_p - 1));
    wr_entry.eof   = wr_entry.eol && (line_q == lw_c'(frame_lines_p - 1));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ID_HI;
      id_hi_q    <= '0;
      skip_q     <= 1'b1;
      synced_q   <= 1'b0;
      sync_err_q <= 1'b0;
      overflow_q <= 1'b0;
      expected_q <= '0;
      line_q     <= '0;
      col_q      <= '0;
      byte_cnt_q <= '0;
      sub_q      <= '0;
      shift_q    <= '0;
    end else begin
      sync_err_q <= 1'b0;
      if (valid_i) begin
        unique case (state_q)
          ID_HI: begin
            id_hi_q <= data_i[3:0];
            state_q <= ID_LO;
          end
          ID_LO: begin
            state_q    <= CRC_HI;
            line_q     <= lw_c'(num);
            col_q      <= '0;
            sub_q      <= '0;
            byte_cnt_q <= '0;
            if (is_discard) begin
              skip_q <= 1'b1;
            end else if (num_bad || (synced_q && seq_bad)) begin
              skip_q     <= 1'b1;
              sync_err_q <= 1'b1;
              synced_q   <= 1'b0;
            end else if (!synced_q && (num != '0)) begin
              skip_q <= 1'b1;
            end else begin
              skip_q   <= 1'b0;
              synced_q <= 1'b1;
            end
          end
          CRC_HI: state_q <= CRC_LO;
          CRC_LO: state_q <= PAYLOAD;
          PAYLOAD: begin
            byte_cnt_q <= byte_cnt_q + 1'b1;
            if (!skip_q) begin
              shift_q <= shw_c'({shift_q, data_i});
              if (last_sub) begin
                sub_q <= '0;
                col_q <= col_q + 1'b1;
              end else begin
                sub_q <= sub_q + 1'b1;
              end
            end
            if (last_byte) begin
              state_q <= ID_HI;
              if (!skip_q) begin
                expected_q <= (line_q == lw_c'(frame_lines_p - 1)) ? '0 : line_q + 1'b1;
              end
            end
          end
          default: state_q <= ID_HI;
        endcase
      end
      // A dropped pixel abandons the frame until the next packet 0.
      if (drop) begin
        overflow_q <= 1'b1;
        synced_q   <= 1'b0;
        skip_q     <= 1'b1;
      end
    end
  end

  vospi_packet_parser_if #(.width_p(ew_c)) out_if ();

  assign out_if.ready = ready_i;

  vospi_out_fifo #(
    .width_p (ew_c),
    .depth_p (fifo_depth_p)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .wr_en_i   (pix_done),
    .wr_data_i (wr_entry),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .rd_if     (out_if.master)
  );

  assign head       = out_if.data;
  assign valid_o    = out_if.valid;
  assign pixel_o    = head.pixel[pw_c-1:0];
  assign line_o     = head.line[lw_c-1:0];
  assign col_o      = head.col[cw_c-1:0];
  assign sof_o      = head.sof;
  assign eol_o      = head.eol;
  assign eof_o      = head.eof;
  assign sync_err_o = sync_err_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_vospi_packet_parser.sv
// Directed bench for vospi_packet_parser: full frame, discards, sequence
// error, FIFO overflow, 3-byte pixels and mid-packet reset.
module tb_vospi_packet_parser;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       valid_i;
  logic [7:0] data_i;

  always #5 clk = ~clk;

  vospi_packet_parser_if #(.width_p(16)) pix_if ();

  logic [5:0] line_o;
  logic [6:0] col_o;
  logic       sof_o, eol_o, eof_o, sync_err_o, overflow_o;

  vospi_packet_parser #(
    .pixel_bytes_p (2),
    .line_pixels_p (80),
    .frame_lines_p (60),
    .fifo_depth_p  (16)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .pixel_o    (pix_if.data),
    .line_o     (line_o),
    .col_o      (col_o),
    .sof_o      (sof_o),
    .eol_o      (eol_o),
    .eof_o      (eof_o),
    .valid_o    (pix_if.valid),
    .ready_i    (pix_if.ready),
    .sync_err_o (sync_err_o),
    .overflow_o (overflow_o)
  );

  logic [23:0] pixel3;
  logic        line3, col3, sof3, eol3, eof3, valid3, ready3, err3, ovf3;

  vospi_packet_parser #(
    .pixel_bytes_p (3),
    .line_pixels_p (2),
    .frame_lines_p (2),
    .fifo_depth_p  (16)
  ) dut3 (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .pixel_o    (pixel3),
    .line_o     (line3),
    .col_o      (col3),
    .sof_o      (sof3),
    .eol_o      (eol3),
    .eof_o      (eof3),
    .valid_o    (valid3),
    .ready_i    (ready3),
    .sync_err_o (err3),
    .overflow_o (ovf3)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] obs_q[$];
  int          err_cnt = 0;

  always @(negedge clk) begin
    if (pix_if.valid && pix_if.ready)
      obs_q.push_back({pix_if.data, line_o, col_o, sof_o, eol_o, eof_o});
    if (sync_err_o)
      err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_i  = b;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_payload(input int ln, input int npix);
    for (int c = 0; c < npix; c++) begin
      send_byte(8'(ln));
      send_byte(8'(c));
    end
  endtask

  task automatic send_packet(input logic [15:0] id, input int ln);
    send_byte(id[15:8]);
    send_byte(id[7:0]);
    send_byte(8'h12);
    send_byte(8'h34);
    send_payload(ln, 80);
    valid_i = 1'b0;
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
  endtask

  // Pixel index i is line i/80, column i%80, value {line, col}.
  task automatic check_seq(input int qs, input int first, input int n);
    for (int k = 0; k < n; k++) begin
      int          i;
      int          ln;
      int          cl;
      logic [31:0] e;
      i  = first + k;
      ln = i / 80;
      cl = i % 80;
      e  = {8'(ln), 8'(cl), 6'(ln), 7'(cl), 1'(i == 0), 1'(cl == 79), 1'(i == 4799)};
      if (qs + k < obs_q.size())
        chk($sformatf("pix%0d", i), obs_q[qs + k], e);
    end
  endtask

  int base;
  int ebase;

  initial begin
    reset_i     = 1'b1;
    valid_i     = 1'b0;
    data_i      = 8'h00;
    pix_if.ready = 1'b1;
    ready3      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(pix_if.valid), 0);
    chk("rst_pixel", 32'(pix_if.data), 0);
    chk("rst_linecol", {line_o, col_o}, 0);
    chk("rst_flags", {sof_o, eol_o, eof_o, sync_err_o, overflow_o}, 0);
    reset_i = 1'b0;
    idle(2);

    // Full frame, ready held high.
    base  = obs_q.size();
    ebase = err_cnt;
    for (int n = 0; n < 60; n++) send_packet(16'(n), n);
    idle(5);
    chk("frame_count", obs_q.size() - base, 4800);
    check_seq(base, 0, 4800);
    chk("frame_err", err_cnt - ebase, 0);
    chk("frame_ovf", 32'(overflow_o), 0);

    // Discard packets interleaved.
    do_reset();
    base  = obs_q.size();
    ebase = err_cnt;
    for (int n = 0; n < 60; n++) begin
      send_packet(16'h0F00, 0);
      send_packet(16'(n), n);
    end
    idle(5);
    chk("disc_count", obs_q.size() - base, 4800);
    check_seq(base, 0, 4800);
    chk("disc_err", err_cnt - ebase, 0);

    // Sequence gap 0,1,2,4.
    do_reset();
    base  = obs_q.size();
    ebase = err_cnt;
    for (int n = 0; n < 3; n++) send_packet(16'(n), n);
    chk("seq_noerr", err_cnt - ebase, 0);
    send_byte(8'h00);
    send_byte(8'h04);
    chk("seq_pulse", 32'(sync_err_o), 1);
    send_byte(8'h12);
    chk("seq_pulse_end", 32'(sync_err_o), 0);
    send_byte(8'h34);
    send_payload(4, 80);
    send_packet(16'd5, 5);
    send_packet(16'd0, 0);
    idle(5);
    chk("seq_count", obs_q.size() - base, 320);
    check_seq(base, 0, 240);
    check_seq(base + 240, 0, 80);
    chk("seq_err_once", err_cnt - ebase, 1);

    // Overflow with ready low through packet 0.
    do_reset();
    pix_if.ready = 1'b0;
    base = obs_q.size();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h12);
    send_byte(8'h34);
    send_payload(0, 16);
    chk("ovf_before", 32'(overflow_o), 0);
    chk("ovf_head_valid", 32'(pix_if.valid), 1);
    chk("ovf_head_pix", 32'(pix_if.data), 32'h0000);
    send_byte(8'h00);
    send_byte(8'h10);
    chk("ovf_set", 32'(overflow_o), 1);
    for (int c = 17; c < 80; c++) begin
      send_byte(8'h00);
      send_byte(8'(c));
    end
    send_packet(16'd1, 1);
    chk("ovf_head_hold", 32'(pix_if.data), 32'h0000);
    pix_if.ready = 1'b1;
    idle(20);
    chk("ovf_drain_count", obs_q.size() - base, 16);
    check_seq(base, 0, 16);
    send_packet(16'd0, 0);
    idle(5);
    chk("ovf_resume_count", obs_q.size() - base, 96);
    check_seq(base + 16, 0, 80);
    chk("ovf_sticky", 32'(overflow_o), 1);

    // Reset in the middle of packet 5's payload.
    do_reset();
    for (int n = 0; n < 5; n++) send_packet(16'(n), n);
    idle(5);
    pix_if.ready = 1'b0;
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h12);
    send_byte(8'h34);
    send_payload(5, 10);
    chk("mrst_pre_valid", 32'(pix_if.valid), 1);
    valid_i = 1'b0;
    #2;
    reset_i = 1'b1;
    #1;
    chk("mrst_valid", 32'(pix_if.valid), 0);
    chk("mrst_pixel", {pix_if.data, line_o, col_o, sof_o, eol_o, eof_o}, 0);
    chk("mrst_flags", {sync_err_o, overflow_o}, 0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    pix_if.ready = 1'b1;
    base  = obs_q.size();
    ebase = err_cnt;
    send_packet(16'd6, 6);
    send_packet(16'd0, 0);
    idle(5);
    chk("mrst_count", obs_q.size() - base, 80);
    check_seq(base, 0, 80);
    chk("mrst_err", err_cnt - ebase, 0);

    // 3-byte pixels on the second instance.
    do_reset();
    ready3 = 1'b0;
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hAA);
    send_byte(8'hBB);
    chk("rgb_not_yet", 32'(valid3), 0);
    send_byte(8'hCC);
    chk("rgb_valid", 32'(valid3), 1);
    chk("rgb_pixel0", 32'(pixel3), 32'h00AABBCC);
    chk("rgb_tag0", {line3, col3, sof3, eol3, eof3}, 5'b00100);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    valid_i = 1'b0;
    chk("rgb_hold", 32'(pixel3), 32'h00AABBCC);
    ready3 = 1'b1;
    @(posedge clk);
    #1;
    ready3 = 1'b0;
    chk("rgb_pixel1", 32'(pixel3), 32'h00112233);
    chk("rgb_tag1", {line3, col3, sof3, eol3, eof3}, 5'b01010);
    chk("rgb_status", {err3, ovf3}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vospi_packet_parser.md
Name: vospi_packet_parser

Overview:
Parametrised successor to the camera's byte-to-pixel collection stage. It consumes the raw VoSPI byte stream from vospi_master, parses the 4-byte packet header, drops discard packets and checks packet sequence. It then assembles big-endian pixels of pixel_bytes_p bytes, tags each pixel with line/column and frame markers, and buffers them in a FIFO that drives a valid/ready handshake into the framebuffer.

Parameters:
pixel_bytes_p  2  bytes per pixel (1, 2 or 3; 3 = RGB888 mode)
line_pixels_p  80  pixels per packet/line
frame_lines_p  60  video packets per frame
fifo_depth_p  16  output FIFO entries, power of two, >= 2

Ports:
clk_i  in  1  single clock
reset_i  in  1  reset, asynchronous, active-high
data_i  in  8  VoSPI byte
valid_i  in  1  data_i valid; cannot be stalled
pixel_o  out  8*pixel_bytes_p  assembled pixel, first byte is the MSB
line_o  out  $clog2(frame_lines_p)  packet/line number of pixel
col_o  out  $clog2(line_pixels_p)  column of pixel
sof_o  out  1  pixel is line 0, col 0
eol_o  out  1  pixel is the last column
eof_o  out  1  pixel is the last column of the last line
valid_o  out  1  FIFO head valid
ready_i  in  1  downstream accepts head
sync_err_o  out  1  one-cycle pulse on sequence error
overflow_o  out  1  sticky; FIFO full when a pixel completed

Behaviour:
- Reset: async, active-high. All outputs 0, FIFO empty, FSM in ID_HI, synced=0, expected=0, overflow_o=0.
- Only bytes with valid_i=1 advance the FSM; idle cycles hold state.
- FSM states:
  - ID_HI: capture byte, go to ID_LO.
  - ID_LO: form ID = {hi, lo}, then classify:
    - Discard (ID[11:8]==4'hF): go to CRC_HI, mark packet skip.
    - Otherwise num = ID[11:0]:
      - num >= frame_lines_p: skip packet, pulse sync_err_o, clear synced.
      - !synced and num != 0: skip packet silently.
      - !synced and num == 0: set synced.
      - synced and num != expected: skip packet, pulse sync_err_o, clear synced.
    - sync_err_o asserts on the cycle after the ID_LO byte.
  - CRC_HI -> CRC_LO: CRC bytes are ignored.
  - CRC_LO -> PAYLOAD.
  - PAYLOAD: consume exactly line_pixels_p*pixel_bytes_p bytes, then return to ID_HI.
- Pixel assembly (non-skipped packets only):
  - Byte counter 0..pixel_bytes_p-1; shift register builds the pixel big-endian.
  - On the final byte, a pixel is written to the FIFO with line=num, col=pixel index, and sof/eol/eof flags.
- Sequencing:
  - expected increments at the end of each accepted packet.
  - After line frame_lines_p-1, expected wraps to 0.
  - Skipped and discard packets never change expected.
- FIFO:
  - First-word-fall-through; each entry holds {pixel, line, col, sof, eol, eof}.
  - Write-to-valid_o latency is 1 cycle when empty.
  - Head is held stable while valid_o & !ready_i.
  - Simultaneous read and write when full is legal and counts as not full.
- Overflow: a pixel completes with the FIFO full and no read that cycle.
  - The pixel is dropped and overflow_o is set, held until reset.
  - synced is cleared, so the rest of the frame is dropped; output resumes at the next packet 0.
- Mid-packet reset aborts immediately; the next packet is treated as unsynced.

Decomposition:
- Package vospi_pkg:
  - header_bytes_c=4, discard_mask_c=4'hF.
  - FSM state enum {ID_HI, ID_LO, CRC_HI, CRC_LO, PAYLOAD}.
  - Packed struct pixel_entry_t.
- One sub-module: vospi_out_fifo.
  - Parametrised width/depth; FWFT with full/empty flags.
  - Reset async, active-high.

Test Plan:
- Full frame of 60 packets x 80 px, pixel = line*256+col, ready_i=1 -> 4800 pixels in order:
  - sof only on pixel 0x0000; eol on every col 79; eof only on 0x3B4F.
  - sync_err_o=0, overflow_o=0.
- Discard packets (ID 0x0F00) inserted between each video packet -> output identical to the full-frame scenario.
- Packets 0,1,2,4 -> sync_err_o pulses once after packet 4 ID_LO; 240 pixels out (lines 0-2); line 4 is not output; output resumes at the next packet 0.
- ready_i=0 throughout packet 0, bytes every cycle:
  - 16 pixels are buffered and the 17th sets overflow_o=1.
  - No further pixels are written until the next packet 0.
  - overflow_o stays 1 after ready_i returns.
- pixel_bytes_p=3: payload bytes AA BB CC -> pixel_o=24'hAABBCC, col_o=0.
- reset_i asserted mid-payload of packet 5 -> outputs 0 in the same cycle and FIFO empty; after release, packet 6 is skipped and packet 0 is output.
